// File: rtl/saida_pkg.sv
// Shared types and constants for the decimal output peripheral: FSM states,
// default widths and the active-low seven-segment encoding.
package saida_pkg;

  localparam int LARGURA_PADRAO = 18;
  localparam int DIGITOS_PADRAO = 6;

  typedef enum logic [1:0] {
    OCIOSO,
    CONVERTE,
    FIM
  } estado_t;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_0       = 7'h40;
  localparam logic [6:0] SEG_1       = 7'h79;
  localparam logic [6:0] SEG_2       = 7'h24;
  localparam logic [6:0] SEG_3       = 7'h30;
  localparam logic [6:0] SEG_4       = 7'h19;
  localparam logic [6:0] SEG_5       = 7'h12;
  localparam logic [6:0] SEG_6       = 7'h02;
  localparam logic [6:0] SEG_7       = 7'h78;
  localparam logic [6:0] SEG_8       = 7'h00;
  localparam logic [6:0] SEG_9       = 7'h10;
  localparam logic [6:0] SEG_APAGADO = 7'h7F;

  function automatic logic [6:0] seg_codigo(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_APAGADO;
    endcase
  endfunction

endpackage

// File: rtl/saida_dados_if.sv
// Bus between the control unit (master) and the display peripheral (slave).
interface saida_dados_if #(
  parameter int LARGURA = saida_pkg::LARGURA_PADRAO,
  parameter int DIGITOS = saida_pkg::DIGITOS_PADRAO
);

  logic                   out;
  logic [LARGURA-1:0]     valor;
  logic                   ocupado;
  logic                   pronto;
  logic [4*DIGITOS-1:0]   bcd;
  logic [7*DIGITOS-1:0]   hex;

  modport master (
    output out, valor,
    input  ocupado, pronto, bcd, hex
  );

  modport slave (
    input  out, valor,
    output ocupado, pronto, bcd, hex
  );

endinterface

// File: rtl/saida_dados_decod7seg.sv
// Combinational BCD nibble to active-low seven-segment decoder with blanking.
module decod7seg
  import saida_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_apaga,
  output logic [6:0] o_seg
);

  assign o_seg = i_apaga ? SEG_APAGADO : seg_codigo(i_nibble);

endmodule

// File: rtl/saida_dados.sv
// OUT-instruction display peripheral: rising-edge request, sequential
// double-dabble binary-to-BCD conversion, six blanked seven-segment digits.
module saida_dados
  import saida_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int DIGITOS = DIGITOS_PADRAO
) (
  input  logic          clock,
  input  logic          reset,
  saida_dados_if.slave  io
);

  localparam int CNT_W = $clog2(LARGURA + 1);
  localparam int BCD_W = 4 * DIGITOS;

  estado_t              r_estado;
  logic                 r_out_ant;
  logic [CNT_W-1:0]     r_cont;
  logic [LARGURA-1:0]   r_desloc;
  logic [BCD_W-1:0]     r_acum;
  logic [BCD_W-1:0]     r_bcd;
  logic [7*DIGITOS-1:0] r_hex;
  logic                 r_ocupado;
  logic                 r_pronto;

  logic                 w_pedido;
  logic [BCD_W-1:0]     w_ajustado;
  logic [DIGITOS-1:0]   w_apaga;
  logic [7*DIGITOS-1:0] w_hex;

  assign w_pedido = io.out & ~r_out_ant;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_ajustado = r_acum;
    for (int k = 0; k < DIGITOS; k++) begin
      if (r_acum[4*k +: 4] >= 4'd5)
        w_ajustado[4*k +: 4] = r_acum[4*k +: 4] + 4'd3;
    end
  end

  // A digit is blanked when it and every digit above it are zero; units never blank.
  always_comb begin : blanking
    logic zeros_acima;
    zeros_acima = 1'b1;
    w_apaga     = '0;
    for (int k = DIGITOS - 1; k > 0; k--) begin
      zeros_acima = zeros_acima && (r_acum[4*k +: 4] == 4'd0);
      w_apaga[k]  = zeros_acima;
    end
  end

  for (genvar k = 0; k < DIGITOS; k++) begin : g_dig
    decod7seg u_dec (
      .i_nibble (r_acum[4*k +: 4]),
      .i_apaga  (w_apaga[k]),
      .o_seg    (w_hex[7*k +: 7])
    );
  end

  // NOTE: state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado  <= OCIOSO;
      r_out_ant <= 1'b0;
      r_cont    <= '0;
      r_desloc  <= '0;
      r_acum    <= '0;
      r_bcd     <= '0;
      r_hex     <= {DIGITOS{SEG_APAGADO}};
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_out_ant <= io.out;
      r_pronto  <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (w_pedido) begin
            r_desloc  <= io.valor;
            r_acum    <= '0;
            r_cont    <= '0;
            r_ocupado <= 1'b1;
            r_estado  <= CONVERTE;
          end
        end
        CONVERTE: begin
          {r_acum, r_desloc} <= {w_ajustado, r_desloc} << 1;
          r_cont             <= r_cont + CNT_W'(1);
          if (r_cont == CNT_W'(LARGURA - 1))
            r_estado <= FIM;
        end
        FIM: begin
          r_bcd     <= r_acum;
          r_hex     <= w_hex;
          r_pronto  <= 1'b1;
          r_ocupado <= 1'b0;
          r_estado  <= OCIOSO;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign io.ocupado = r_ocupado;
  assign io.pronto  = r_pronto;
  assign io.bcd     = r_bcd;
  assign io.hex     = r_hex;

endmodule

// File: tb/tb_saida_dados.sv
// Scoreboard bench for saida_dados: the driver queues expected displays,
// a negedge monitor checks timing, stability and each pronto against the queue.
module tb_saida_dados;

  typedef struct {
    string       nome;
    logic [23:0] bcd;
    logic [41:0] hex;
  } esperado_t;

  localparam logic [41:0] TUDO_APAGADO = {6{7'h7F}};

  logic clock;
  logic reset;

  saida_dados_if ifc ();

  saida_dados dut (
    .clock (clock),
    .reset (reset),
    .io    (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  esperado_t   fila[$];
  logic [23:0] exib_bcd = 24'h0;
  logic [41:0] exib_hex = TUDO_APAGADO;
  int          corrida  = 0;
  logic        ocup_ant = 1'b0;

  task automatic check(input string nome, input logic [63:0] obtido, input logic [63:0] esperado);
    n_total++;
    if (obtido === esperado) n_pass++;
    else $display("FAIL %s: obtido=%h esperado=%h", nome, obtido, esperado);
  endtask

  // Monitor: every sample away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      corrida  = 0;
      ocup_ant = 1'b0;
    end else begin
      if (ifc.pronto) begin
        check("pronto_apos_ocupado", {62'd0, ocup_ant, ifc.ocupado}, 64'd2);
        check("ocupado_ciclos", 64'(corrida), 64'd19);
        if (fila.size() == 0) begin
          n_total++;
          $display("FAIL pronto_inesperado: bcd=%h, nenhum valor pendente", ifc.bcd);
        end else begin
          esperado_t e;
          e = fila.pop_front();
          check({e.nome, "_bcd"}, 64'(ifc.bcd), 64'(e.bcd));
          check({e.nome, "_hex"}, 64'(ifc.hex), 64'(e.hex));
          exib_bcd = e.bcd;
          exib_hex = e.hex;
        end
      end else begin
        check("exibicao_estavel_bcd", 64'(ifc.bcd), 64'(exib_bcd));
        check("exibicao_estavel_hex", 64'(ifc.hex), 64'(exib_hex));
      end
      ocup_ant = ifc.ocupado;
      corrida  = ifc.ocupado ? corrida + 1 : 0;
    end
  end

  task automatic esperar(input string nome, input logic [23:0] bcd, input logic [41:0] hex);
    esperado_t e;
    e.nome = nome;
    e.bcd  = bcd;
    e.hex  = hex;
    fila.push_back(e);
  endtask

  task automatic pulso(input logic [17:0] v);
    @(negedge clock);
    ifc.valor = v;
    ifc.out   = 1'b1;
    @(negedge clock);
    ifc.out   = 1'b0;
  endtask

  task automatic esperar_fim(input string nome);
    int ciclos;
    ciclos = 0;
    while ((fila.size() != 0 || ifc.ocupado || ifc.pronto) && ciclos < 100) begin
      @(negedge clock);
      ciclos++;
    end
    check({nome, "_fila_vazia"}, 64'(fila.size()), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    ifc.out   = 1'b0;
    ifc.valor = '0;
    repeat (3) @(negedge clock);
    check("reset_hex",     64'(ifc.hex), 64'(TUDO_APAGADO));
    check("reset_bcd",     64'(ifc.bcd), 64'd0);
    check("reset_ocupado", 64'(ifc.ocupado), 64'd0);
    check("reset_pronto",  64'(ifc.pronto), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    esperar("v12345", 24'h012345, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
    pulso(18'd12345);
    esperar_fim("v12345");

    esperar("v262143", 24'h262143, {7'h24, 7'h02, 7'h24, 7'h79, 7'h19, 7'h30});
    pulso(18'd262143);
    esperar_fim("v262143");

    esperar("v0", 24'h000000, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    pulso(18'd0);
    esperar_fim("v0");

    esperar("v100", 24'h000100, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40});
    pulso(18'd100);
    esperar_fim("v100");

    // Held-high request converts once; a rise during the next conversion is dropped.
    esperar("v7", 24'h000007, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78});
    @(negedge clock);
    ifc.valor = 18'd7;
    ifc.out   = 1'b1;
    repeat (40) @(negedge clock);
    ifc.out   = 1'b0;
    esperar("v58", 24'h000058, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h00});
    pulso(18'd58);
    repeat (5) @(negedge clock);
    ifc.valor = 18'd999;
    ifc.out   = 1'b1;
    repeat (3) @(negedge clock);
    ifc.out   = 1'b0;
    esperar_fim("v58");
    repeat (10) @(negedge clock);

    // Reset in the middle of a conversion over a displayed 42.
    esperar("v42", 24'h000042, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
    pulso(18'd42);
    esperar_fim("v42");
    pulso(18'd999);
    repeat (9) @(negedge clock);
    reset    = 1'b1;
    exib_bcd = 24'h0;
    exib_hex = TUDO_APAGADO;
    @(negedge clock);
    check("aborto_hex",     64'(ifc.hex), 64'(TUDO_APAGADO));
    check("aborto_bcd",     64'(ifc.bcd), 64'd0);
    check("aborto_ocupado", 64'(ifc.ocupado), 64'd0);
    check("aborto_pronto",  64'(ifc.pronto), 64'd0);
    reset = 1'b0;
    repeat (25) @(negedge clock);

    esperar("v2024", 24'h002024, {7'h7F, 7'h7F, 7'h24, 7'h40, 7'h24, 7'h19});
    pulso(18'd2024);
    esperar_fim("v2024");

    repeat (30) @(negedge clock);
    check("fila_final", 64'(fila.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/saida_dados.md
# saida_dados

Output-side peripheral for the processor's `OUT` instruction. On a rising edge of the `out` request it latches an 18-bit unsigned value and converts it to decimal with a sequential shift-and-add-3 (double-dabble) engine. It then drives six active-low seven-segment digits with leading-zero blanking. It complements the switch-input block, sits beside it on the processor's I/O strobes, and reports `ocupado`/`pronto` so the control unit can stall until the display has updated.

## Interface
- `LARGURA`, 18: width of `valor`.
- `DIGITOS`, 6: decimal digits; must satisfy 10^DIGITOS > 2^LARGURA.
- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `out` in 1: request from the control unit, level; only its rising edge is acted on.
- `valor` in LARGURA: value to display, sampled on the accepting edge.
- `ocupado` out 1: conversion in progress.
- `pronto` out 1: one-cycle pulse, display just updated.
- `bcd` out 4*DIGITOS: displayed BCD value, digit 0 (units) in [3:0].
- `hex` out 7*DIGITOS: segments, active-low, digit k in [7k+6:7k], bit 0 = segment a … bit 6 = segment g.

## Operation
- Edge detect: `out_ant` register; request = `out & ~out_ant`; `out_ant` resets to 0, so `out` already high after reset counts as a request.
- FSM states OCIOSO, CONVERTE, FIM.
- OCIOSO: on request, latch `valor` into shift register, clear BCD accumulator, counter := 0, go CONVERTE; `ocupado` := 1.
- CONVERTE: per cycle, for every BCD nibble >= 5 add 3, then shift {bcd, shift} left 1; counter++; after LARGURA iterations go FIM.
- FIM: copy accumulator to `bcd`, recompute `hex`, `pronto` := 1, `ocupado` := 0, go OCIOSO.
- Requests while in CONVERTE/FIM are dropped, not queued. A held-high `out` yields exactly one conversion and must return low to re-arm.
- Blanking: digits above the most significant nonzero digit show 7'h7F. Value 0 shows "0" on digit 0 only.
- Encoding, active-low a..g: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Nibbles >9 cannot occur; map to 7'h7F.
- Counter width: clog2(LARGURA+1). Add-3 operates on 4-bit nibbles with no carry out.

## Timing
- Reset values: `ocupado`=0, `pronto`=0, `bcd`=0, every `hex` digit=7'h7F (blank), state OCIOSO, `out_ant`=0.
- Request sampled at edge 0. Iterations run at edges 1..LARGURA. FIM at edge LARGURA+1 updates `bcd`/`hex` and raises `pronto` for exactly that cycle.
- `ocupado` is high from after edge 0 until edge LARGURA+1 (LARGURA+1 cycles, 19 at default).
- The next request can be accepted at edge LARGURA+2.
- `hex`/`bcd` hold the previous value throughout a conversion and change only in FIM.
- Reset mid-conversion aborts: display blanks, no `pronto`.

## Structure
- Package `saida_pkg`: state enum, seven-segment constants (digits 0–9, blank), `DIGITOS` and `LARGURA` defaults.
- Sub-module `decod7seg`: combinational nibble+blank → 7 segments, instantiated DIGITOS times.
- The FSM, edge detector, and double-dabble datapath live in `saida_dados`.

## Test plan
- Reset held 3 cycles → all `hex`=7F, `bcd`=0, `ocupado`=0, `pronto`=0.
- `valor`=12345, one-cycle `out` → `ocupado` high 19 cycles; `pronto` one cycle at edge 19; `bcd`=0x012345; digit5=7F; digits4..0 = 79,24,30,19,12.
- `valor`=262143 → `bcd`=0x262143; all six digits lit: 24,02,24,79,19,30.
- `valor`=0 → digit0=40, digits1..5=7F; `valor`=100 → 79,40,40 with upper digits blank (internal zeros shown).
- `out` held high 40 cycles with `valor`=7, then a second rise during the next conversion → exactly one `pronto` per accepted rise, mid-conversion rise ignored, display shows 7 then the new value.
- Reset asserted at cycle 10 of a conversion of 999 over a displayed 42 → next cycle display blank, `ocupado`=0, no `pronto`; a new request afterwards converts normally.
